dm_port_arbiter: RTL and testbench
==================================

# dm_port_arbiter

Shares the single data memory between two requesters: the pipeline MEM stage (core port) and a debug/loader master (aux port). It grants the memory each cycle, generates byte enables from the RISC-V load/store funct3, checks alignment, and sign/zero-extends load data. The core port has priority, bounded by a starvation counter for aux. The block sits between the MEM stage and the DM instance, driving its `w_en`, `address` and `write_data` and consuming its `read_data`.

## Interface
Parameters:
- `ADDR_W`, 16, byte address width, matches the DM address port.
- `STARVE_LIMIT`, 4, number of consecutive denied aux cycles after which aux wins the next conflict.

Ports:
- `clk`  in  1  single clock; DM writes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `core_req`  in  1  MEM stage has a load or store this cycle.
- `core_we`  in  1  1 = store, 0 = load.
- `core_funct3`  in  3  load/store funct3.
- `core_addr`  in  ADDR_W  byte address.
- `core_wdata`  in  32  store data, low-justified.
- `core_rdata`  out  32  extended load result, combinational.
- `core_stall`  out  1  core not granted this cycle; MEM stage must hold.
- `core_fault`  out  1  misaligned access or illegal funct3; no memory effect.
- `aux_valid`  in  1  aux request present.
- `aux_ready`  out  1  aux granted; a transfer occurs when `aux_valid && aux_ready`.
- `aux_we`  in  1  1 = write.
- `aux_be`  in  4  aux byte enables.
- `aux_addr`  in  ADDR_W  aux byte address.
- `aux_wdata`  in  32  aux write data.
- `aux_rvalid`  out  1  one-cycle acknowledge, the cycle after each aux transfer.
- `aux_rdata`  out  32  registered aux read data.
- `dm_w_en`  out  4  DM byte write enables.
- `dm_address`  out  ADDR_W  DM address.
- `dm_write_data`  out  32  DM write data.
- `dm_read_data`  in  32  DM combinational read data. Valid only in cycles with `dm_w_en == 0`; the DM holds its last value otherwise.

## Operation
- Core decode:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000 (`w_en` 0001), SH 001 (0011), SW 010 (1111).
  - Any other funct3 raises a fault.
- Alignment: H requires `addr[0]==0`; W requires `addr[1:0]==0`. A violation sets `core_fault=1` for that cycle with no stall and no write, and the core does not consume the memory.
- Arbitration, evaluated combinationally each cycle:
  - Only valid core (no fault) requesting: core granted.
  - Only aux requesting: aux granted.
  - Both requesting: core wins unless `starve_cnt == STARVE_LIMIT`, in which case aux wins.
- Starvation counter `starve_cnt`:
  - Increments, saturating at `STARVE_LIMIT`, on each cycle with `aux_valid && !aux_ready`.
  - Clears on an aux transfer, or when `aux_valid` is 0.
- Grant effects:
  - Granted source drives `dm_address`/`dm_write_data`/`dm_w_en`.
  - No grant: `dm_w_en=0` and `dm_address` holds the core address.
- Load extension: `core_rdata` is `dm_read_data` sign- or zero-extended per funct3 (LB/LBU from [7:0], LH/LHU from [15:0]). It is 0 when no load is granted.
- Aux port:
  - A write uses `aux_be` directly; `aux_be==0` with `aux_we=1` is a no-op that is still acknowledged.
  - A read captures `dm_read_data` into `aux_rdata` at the transfer edge.
  - `aux_rdata` holds its value across write transfers.
- `core_stall = core_req && !fault && !core_grant`.

## Timing
- Core access: zero added latency. Load data and write enables appear in the granted cycle; the write commits at the following `clk` edge.
- Aux access: `aux_ready` is combinational. `aux_rvalid` pulses exactly one cycle after the transfer; back-to-back transfers give back-to-back `aux_rvalid`.
- Reset (synchronous): `starve_cnt=0`, `aux_rvalid=0`, `aux_rdata=0`. While `rst` is high, `dm_w_en=0`, `aux_ready=0`, `core_stall=0` and `core_fault=0`.
- Reset mid-operation: a transfer in the reset cycle is discarded and no `aux_rvalid` follows.
- An aux request withdrawn while stalled is legal; the counter clears.

## Structure
- Package `dm_pkg` holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the `ADDR_W` default;
  - grant enum `{GNT_NONE, GNT_CORE, GNT_AUX}`.
- Sub-module `dm_lane_align` (combinational) performs funct3 → byte enables, the alignment check and load extension. It is instantiated once for the core path.
- Top level holds the arbiter, the starvation counter and the aux response registers.

## Test plan
- Core SW 0xDEADBEEF at 0x0100, then LB at 0x0103 → `core_rdata=0xFFFFFFDE`. LBU at the same address → 0x000000DE.
- Core SH at 0x0101 → `core_fault=1`, `dm_w_en=0`, no stall. A following LW at 0x0100 returns the unchanged word.
- Core and aux both requesting continuously, `STARVE_LIMIT=4` → aux denied for 4 cycles, granted in the 5th (core stalls that cycle), then the pattern repeats.
- Aux write `be=0110`, data 0x11223344, at 0x0200, then aux read at 0x0200 → `aux_rvalid` one cycle after each transfer. Read data shows bytes 1 and 2 as 0x33 and 0x22, other bytes unchanged.
- Assert `rst` in the cycle of an aux read transfer → no `aux_rvalid` next cycle, `aux_rdata=0`, `starve_cnt=0`.
- Core funct3=011 load → `core_fault=1`, `core_rdata=0`. An aux request in the same cycle is granted.

Source files
------------

// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_pkg
//  Description : Shared constants and types for the data-memory port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package dm_pkg;

    localparam int ADDR_W_DEFAULT = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_AUX  = 2'd2
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/dm_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dm_lane_align
//  Description : funct3 decode to byte enables, alignment/legality check and
//                load sign/zero extension for one memory port.
//  Revision    : 1.0  initial release
// ============================================================================
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw_rdata,
    output logic [3:0]  byte_en,
    output logic        fault,
    output logic [31:0] load_data
);

    logic w_illegal;
    logic w_misalign;

    always_comb begin
        byte_en    = 4'b0000;
        load_data  = 32'h0;
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        case (funct3)
            F3_B: begin
                byte_en   = 4'b0001;
                load_data = {{24{raw_rdata[7]}}, raw_rdata[7:0]};
            end
            F3_H: begin
                byte_en    = 4'b0011;
                w_misalign = addr_lo[0];
                load_data  = {{16{raw_rdata[15]}}, raw_rdata[15:0]};
            end
            F3_W: begin
                byte_en    = 4'b1111;
                w_misalign = |addr_lo;
                load_data  = raw_rdata;
            end
            // Unsigned variants exist only for loads.
            F3_BU: begin
                w_illegal = we;
                load_data = {24'h0, raw_rdata[7:0]};
            end
            F3_HU: begin
                w_illegal  = we;
                w_misalign = addr_lo[0];
                load_data  = {16'h0, raw_rdata[15:0]};
            end
            default: w_illegal = 1'b1;
        endcase
        fault = w_illegal | w_misalign;
    end

endmodule
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_port_arbiter
//  Description : Shares one data memory between the core MEM stage and an aux
//                master, core-priority with an aux starvation bound.
//  Revision    : 1.0  initial release
// ============================================================================
module dm_port_arbiter
    import dm_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [2:0]        core_funct3,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    output logic              core_fault,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic              aux_we,
    input  logic [3:0]        aux_be,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [31:0]       aux_wdata,
    output logic              aux_rvalid,
    output logic [31:0]       aux_rdata,
    output logic [3:0]        dm_w_en,
    output logic [ADDR_W-1:0] dm_address,
    output logic [31:0]       dm_write_data,
    input  logic [31:0]       dm_read_data
);

    localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               r_aux_rvalid;
    logic [31:0]        r_aux_rdata;

    grant_e      w_grant;
    logic [3:0]  w_core_be;
    logic        w_lane_fault;
    logic [31:0] w_core_load;
    logic        w_core_valid;
    logic        w_aux_xfer;

    dm_lane_align u_core_lane (
        .funct3    (core_funct3),
        .we        (core_we),
        .addr_lo   (core_addr[1:0]),
        .raw_rdata (dm_read_data),
        .byte_en   (w_core_be),
        .fault     (w_lane_fault),
        .load_data (w_core_load)
    );

    assign w_core_valid = core_req && !w_lane_fault;

    always_comb begin
        w_grant = GNT_NONE;
        if (!rst) begin
            if (w_core_valid && aux_valid)
                w_grant = (r_starve_cnt == c_LIMIT) ? GNT_AUX : GNT_CORE;
            else if (w_core_valid)
                w_grant = GNT_CORE;
            else if (aux_valid)
                w_grant = GNT_AUX;
        end
    end

    // With no grant the address follows the core so its load path stays warm.
    always_comb begin
        dm_w_en       = 4'b0000;
        dm_address    = core_addr;
        dm_write_data = core_wdata;
        core_rdata    = 32'h0;
        case (w_grant)
            GNT_CORE: begin
                if (core_we) dm_w_en = w_core_be;
                else         core_rdata = w_core_load;
            end
            GNT_AUX: begin
                dm_address    = aux_addr;
                dm_write_data = aux_wdata;
                if (aux_we) dm_w_en = aux_be;
            end
            default: ;
        endcase
    end

    assign aux_ready  = (w_grant == GNT_AUX);
    assign w_aux_xfer = aux_valid && aux_ready;
    assign core_stall = !rst && w_core_valid && (w_grant != GNT_CORE);
    assign core_fault = !rst && core_req && w_lane_fault;
    assign aux_rvalid = r_aux_rvalid;
    assign aux_rdata  = r_aux_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_aux_rvalid <= 1'b0;
            r_aux_rdata  <= 32'h0;
        end else begin
            r_aux_rvalid <= w_aux_xfer;
            if (w_aux_xfer && !aux_we)
                r_aux_rdata <= dm_read_data;
            if (aux_valid && !aux_ready) begin
                if (r_starve_cnt != c_LIMIT)
                    r_starve_cnt <= r_starve_cnt + c_ONE;
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_port_arbiter
//  Description : Directed vector bench for dm_port_arbiter with a byte-lane
//                data memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [2:0]  core_funct3;
    logic [15:0] core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        core_stall, core_fault;
    logic        aux_valid, aux_ready, aux_we;
    logic [3:0]  aux_be;
    logic [15:0] aux_addr;
    logic [31:0] aux_wdata;
    logic        aux_rvalid;
    logic [31:0] aux_rdata;
    logic [3:0]  dm_w_en;
    logic [15:0] dm_address;
    logic [31:0] dm_write_data, dm_read_data;

    logic [7:0] mem [0:65535];
    int checks   = 0;
    int failures = 0;
    logic prev_xfer;

    always #5 clk = ~clk;

    dm_port_arbiter #(.ADDR_W(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_stall(core_stall), .core_fault(core_fault),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_we(aux_we),
        .aux_be(aux_be), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .dm_w_en(dm_w_en), .dm_address(dm_address),
        .dm_write_data(dm_write_data), .dm_read_data(dm_read_data)
    );

    // Byte-addressed memory: lane i maps to address+i.
    assign dm_read_data = {mem[dm_address + 16'd3], mem[dm_address + 16'd2],
                           mem[dm_address + 16'd1], mem[dm_address]};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (dm_w_en[i]) mem[dm_address + 16'(i)] <= dm_write_data[8*i +: 8];
    end

    typedef struct {
        logic        creq;  logic cwe;  logic [2:0] f3;
        logic [15:0] caddr; logic [31:0] cwdata;
        logic        avalid; logic awe; logic [3:0] abe;
        logic [15:0] aaddr; logic [31:0] awdata;
        logic [31:0] e_rdata; logic e_stall; logic e_fault; logic e_ready;
        logic [3:0]  e_wen; logic [15:0] e_addr;
        logic        e_rvalid; logic [31:0] e_ardata;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [2:0] f3,
                         input logic [15:0] caddr, input logic [31:0] cwdata,
                         input logic avalid, input logic awe, input logic [3:0] abe,
                         input logic [15:0] aaddr, input logic [31:0] awdata);
        core_req = creq; core_we = cwe; core_funct3 = f3;
        core_addr = caddr; core_wdata = cwdata;
        aux_valid = avalid; aux_we = awe; aux_be = abe;
        aux_addr = aaddr; aux_wdata = awdata;
    endtask

    // Core LW at 0x0100 against an aux read at 0x0200; aux must win only at grant_at.
    task automatic run_both(input string tag, input int n, input int grant_at);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            drive(1'b1, 1'b0, 3'b010, 16'h0100, 32'h0, 1'b1, 1'b0, 4'h0, 16'h0200, 32'h0);
            @(negedge clk);
            check({tag, "_ready"}, 32'(aux_ready), 32'(c == grant_at));
            check({tag, "_stall"}, 32'(core_stall), 32'(c == grant_at));
            check({tag, "_rdata"}, core_rdata, (c == grant_at) ? 32'h0 : 32'hDEADBEEF);
            check({tag, "_rvalid"}, 32'(aux_rvalid), 32'(prev_xfer));
            prev_xfer = (c == grant_at);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 16'h0, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        @(negedge clk);
        check("idle_rvalid", 32'(aux_rvalid), 32'(prev_xfer));
        prev_xfer = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        //          creq cwe f3      caddr    cwdata        av   awe  abe     aaddr    awdata
        //          e_rdata       stl  flt  rdy  wen     e_addr   rv   ardata
        vecs[0]  = '{1, 1, 3'b010, 16'h0100, 32'hDEADBEEF, 0, 0, 4'h0, 16'h0000, 32'h0,
                     32'h0,        0, 0, 0, 4'b1111, 16'h0100, 0, 32'h0};
        vecs[1]  = '{1, 0, 3'b000, 16'h0103, 32'h0,        0, 0, 4'h0, 16'h0000, 32'h0,
                     32'hFFFFFFDE, 0, 0, 0, 4'b0000, 16'h0103, 0, 32'h0};
        vecs[2]  = '{1, 0, 3'b100, 16'h0103, 32'h0,        0, 0, 4'h0, 16'h0000, 32'h0,
                     32'h000000DE, 0, 0, 0, 4'b0000, 16'h0103, 0, 32'h0};
        vecs[3]  = '{1, 1, 3'b001, 16'h0101, 32'h0000AAAA, 0, 0, 4'h0, 16'h0000, 32'h0,
                     32'h0,        0, 1, 0, 4'b0000, 16'h0101, 0, 32'h0};
        vecs[4]  = '{1, 0, 3'b010, 16'h0100, 32'h0,        0, 0, 4'h0, 16'h0000, 32'h0,
                     32'hDEADBEEF, 0, 0, 0, 4'b0000, 16'h0100, 0, 32'h0};
        vecs[5]  = '{1, 0, 3'b001, 16'h0102, 32'h0,        0, 0, 4'h0, 16'h0000, 32'h0,
                     32'hFFFFDEAD, 0, 0, 0, 4'b0000, 16'h0102, 0, 32'h0};
        vecs[6]  = '{1, 0, 3'b101, 16'h0102, 32'h0,        0, 0, 4'h0, 16'h0000, 32'h0,
                     32'h0000DEAD, 0, 0, 0, 4'b0000, 16'h0102, 0, 32'h0};
        vecs[7]  = '{1, 1, 3'b000, 16'h0104, 32'h12345680, 0, 0, 4'h0, 16'h0000, 32'h0,
                     32'h0,        0, 0, 0, 4'b0001, 16'h0104, 0, 32'h0};
        vecs[8]  = '{1, 0, 3'b000, 16'h0104, 32'h0,        0, 0, 4'h0, 16'h0000, 32'h0,
                     32'hFFFFFF80, 0, 0, 0, 4'b0000, 16'h0104, 0, 32'h0};
        vecs[9]  = '{1, 0, 3'b010, 16'h0102, 32'h0,        0, 0, 4'h0, 16'h0000, 32'h0,
                     32'h0,        0, 1, 0, 4'b0000, 16'h0102, 0, 32'h0};
        vecs[10] = '{1, 0, 3'b011, 16'h0300, 32'h0,        1, 0, 4'h0, 16'h0100, 32'h0,
                     32'h0,        0, 1, 1, 4'b0000, 16'h0100, 0, 32'h0};
        vecs[11] = '{0, 0, 3'b000, 16'h0000, 32'h0,        1, 1, 4'b0110, 16'h0200, 32'h11223344,
                     32'h0,        0, 0, 1, 4'b0110, 16'h0200, 1, 32'hDEADBEEF};
        vecs[12] = '{0, 0, 3'b000, 16'h0000, 32'h0,        1, 0, 4'h0, 16'h0200, 32'h0,
                     32'h0,        0, 0, 1, 4'b0000, 16'h0200, 1, 32'hDEADBEEF};
        vecs[13] = '{0, 0, 3'b000, 16'h0000, 32'h0,        0, 0, 4'h0, 16'h0000, 32'h0,
                     32'h0,        0, 0, 0, 4'b0000, 16'h0000, 1, 32'h00223300};
        vecs[14] = '{0, 0, 3'b000, 16'h0000, 32'h0,        0, 0, 4'h0, 16'h0000, 32'h0,
                     32'h0,        0, 0, 0, 4'b0000, 16'h0000, 0, 32'h00223300};

        // Reset: outputs forced quiet even with requests present.
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 16'h0, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 3'b010, 16'h0101, 32'h55, 1'b1, 1'b1, 4'hF, 16'h0010, 32'h77);
        @(negedge clk);
        check("rst_ready", 32'(aux_ready), 32'h0);
        check("rst_stall", 32'(core_stall), 32'h0);
        check("rst_fault", 32'(core_fault), 32'h0);
        check("rst_wen", 32'(dm_w_en), 32'h0);
        check("rst_rvalid", 32'(aux_rvalid), 32'h0);
        check("rst_ardata", aux_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 16'h0, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);

        for (int v = 0; v < 15; v++) begin
            @(posedge clk); #1;
            drive(vecs[v].creq, vecs[v].cwe, vecs[v].f3, vecs[v].caddr, vecs[v].cwdata,
                  vecs[v].avalid, vecs[v].awe, vecs[v].abe, vecs[v].aaddr, vecs[v].awdata);
            @(negedge clk);
            check($sformatf("v%0d_rdata", v), core_rdata, vecs[v].e_rdata);
            check($sformatf("v%0d_stall", v), 32'(core_stall), 32'(vecs[v].e_stall));
            check($sformatf("v%0d_fault", v), 32'(core_fault), 32'(vecs[v].e_fault));
            check($sformatf("v%0d_ready", v), 32'(aux_ready), 32'(vecs[v].e_ready));
            check($sformatf("v%0d_wen", v), 32'(dm_w_en), 32'(vecs[v].e_wen));
            check($sformatf("v%0d_addr", v), 32'(dm_address), 32'(vecs[v].e_addr));
            check($sformatf("v%0d_rvalid", v), 32'(aux_rvalid), 32'(vecs[v].e_rvalid));
            check($sformatf("v%0d_ardata", v), aux_rdata, vecs[v].e_ardata);
        end

        // Continuous contention: aux wins every fifth cycle.
        prev_xfer = 1'b0;
        run_both("starveA", 5, 4);
        run_both("starveB", 5, 4);
        idle_cycle();

        // Withdrawn aux request clears the count.
        run_both("wd_pre", 2, -1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'b010, 16'h0100, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0200, 32'h0);
        @(negedge clk);
        check("wd_coregrant_stall", 32'(core_stall), 32'h0);
        run_both("wd_post", 5, 4);
        idle_cycle();

        // Reset during a pending aux read clears count and response registers.
        run_both("rs_pre", 3, -1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rs_ready", 32'(aux_ready), 32'h0);
        check("rs_stall", 32'(core_stall), 32'h0);
        check("rs_rdata", core_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 16'h0, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        @(negedge clk);
        check("rs_rvalid", 32'(aux_rvalid), 32'h0);
        check("rs_ardata", aux_rdata, 32'h0);
        prev_xfer = 1'b0;
        run_both("rs_post", 5, 4);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
